// File: rtl/mdu_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mdu_pkg
// Description : Shared definitions for the multiply/divide unit: MD operation
//               encodings, controller state encoding and small helpers.
// Ports       : none (package)
// Revision    : 1.0 - initial release
// ============================================================================
package mdu_pkg;

    // EX-stage MD operation codes; 6 and 7 are treated as no-ops.
    typedef enum logic [2:0] {
        MD_MULT  = 3'd0,
        MD_MULTU = 3'd1,
        MD_DIV   = 3'd2,
        MD_DIVU  = 3'd3,
        MD_MTHI  = 3'd4,
        MD_MTLO  = 3'd5,
        MD_NOP6  = 3'd6,
        MD_NOP7  = 3'd7
    } md_op_e;

    typedef enum logic [0:0] {
        S_IDLE = 1'b0,
        S_BUSY = 1'b1
    } state_e;

    // Multi-cycle arithmetic ops occupy codes 0..3 (bit 2 clear).
    function automatic logic is_arith(input logic [2:0] op);
        return (op[2] == 1'b0);
    endfunction

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage : mdu_pkg
`default_nettype wire

// File: rtl/mdu_lat_cnt.sv
`default_nettype none
// ============================================================================
// Module      : mdu_lat_cnt
// Description : Loadable down-counter modelling MD latency. Loads on load_i,
//               otherwise counts down and holds at zero.
// Ports       : clk_i      - rising-edge clock
//               reset_i    - asynchronous active-high reset (count -> 0)
//               load_i     - load load_val_i this edge
//               load_val_i - value to load
//               done_o     - count is zero
// Revision    : 1.0 - initial release
// ============================================================================
module mdu_lat_cnt #(
    parameter int W = 5
) (
    input  logic         clk_i,
    input  logic         reset_i,
    input  logic         load_i,
    input  logic [W-1:0] load_val_i,
    output logic         done_o
);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = load_val_i;
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - W'(1);
        end
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign done_o = (cnt_q == '0);

endmodule : mdu_lat_cnt
`default_nettype wire

// File: rtl/mdu_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : mdu_ctrl
// Description : EX-stage multiply/divide unit with sequencing controller.
//               Latches operands on start, models latency with mdu_lat_cnt,
//               owns HI/LO and raises the hazard stall request.
// Ports       : clk_i       - rising-edge clock
//               reset_i     - asynchronous active-high reset
//               start_i     - EX-stage MD op valid this cycle
//               md_op_i     - MD operation code (see mdu_pkg::md_op_e)
//               rs_val_i    - forwarded rs (dividend/multiplicand/MT source)
//               rt_val_i    - forwarded rt (divisor/multiplier)
//               d_is_md_i   - ID-stage instruction is an MD-class op
//               busy_o      - operation in flight
//               md_stall_o  - stall request to the hazard unit
//               hi_o, lo_o  - HI/LO registers
// Revision    : 1.0 - initial release
// ============================================================================
module mdu_ctrl
    import mdu_pkg::*;
#(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic        clk_i,
    input  logic        reset_i,
    input  logic        start_i,
    input  logic [2:0]  md_op_i,
    input  logic [31:0] rs_val_i,
    input  logic [31:0] rt_val_i,
    input  logic        d_is_md_i,
    output logic        busy_o,
    output logic        md_stall_o,
    output logic [31:0] hi_o,
    output logic [31:0] lo_o
);

    localparam int c_cnt_w = $clog2(max_int(MULT_CYCLES, DIV_CYCLES)) + 1;
    localparam logic [c_cnt_w-1:0] c_mult_load = c_cnt_w'(MULT_CYCLES - 1);
    localparam logic [c_cnt_w-1:0] c_div_load  = c_cnt_w'(DIV_CYCLES - 1);

    state_e       state_q;
    md_op_e       op_q;
    logic [31:0]  a_q;
    logic [31:0]  b_q;
    logic [31:0]  hi_q;
    logic [31:0]  lo_q;
    logic         busy_q;
    logic [31:0]  hi_d;
    logic [31:0]  lo_d;

    logic               w_start_acc;
    logic               w_cnt_done;
    logic [c_cnt_w-1:0] w_load_val;

    // ------------------------------------------------------------------
    // Acceptance and latency counter
    // ------------------------------------------------------------------
    assign w_start_acc = start_i && (state_q == S_IDLE) && is_arith(md_op_i);

    // Bit 1 of the op code separates divides (2,3) from multiplies (0,1).
    assign w_load_val = md_op_i[1] ? c_div_load : c_mult_load;

    mdu_lat_cnt #(
        .W (c_cnt_w)
    ) u_lat_cnt (
        .clk_i      (clk_i),
        .reset_i    (reset_i),
        .load_i     (w_start_acc),
        .load_val_i (w_load_val),
        .done_o     (w_cnt_done)
    );

    // ------------------------------------------------------------------
    // Arithmetic on latched operands
    // ------------------------------------------------------------------
    logic [63:0] w_prod_s;
    logic [63:0] w_prod_u;
    logic        w_b_nz;
    logic [31:0] w_b_safe;
    logic [31:0] w_a_mag;
    logic [31:0] w_b_mag;
    logic [31:0] w_uq;
    logic [31:0] w_ur;
    logic [31:0] w_sq;
    logic [31:0] w_sr;
    logic [31:0] w_qu;
    logic [31:0] w_ru;

    assign w_prod_s = 64'($signed(a_q)) * 64'($signed(b_q));
    assign w_prod_u = 64'(a_q) * 64'(b_q);

    // Divisor forced to 1 when zero so the dividers never see /0; the
    // result is discarded in that case anyway.
    assign w_b_nz   = (b_q != 32'd0);
    assign w_b_safe = w_b_nz ? b_q : 32'd1;
    assign w_qu     = a_q / w_b_safe;
    assign w_ru     = a_q % w_b_safe;

    // Signed divide done on magnitudes: avoids the signed-overflow corner
    // (-2^31 / -1) and gives truncation toward zero directly.
    assign w_a_mag = a_q[31] ? (~a_q + 32'd1) : a_q;
    assign w_b_mag = !w_b_nz ? 32'd1 : (b_q[31] ? (~b_q + 32'd1) : b_q);
    assign w_uq    = w_a_mag / w_b_mag;
    assign w_ur    = w_a_mag % w_b_mag;
    assign w_sq    = (a_q[31] ^ b_q[31]) ? (~w_uq + 32'd1) : w_uq;
    assign w_sr    = a_q[31] ? (~w_ur + 32'd1) : w_ur;

    always_comb begin
        hi_d = hi_q;
        lo_d = lo_q;
        case (op_q)
            MD_MULT:  {hi_d, lo_d} = w_prod_s;
            MD_MULTU: {hi_d, lo_d} = w_prod_u;
            MD_DIV: begin
                if (w_b_nz) begin
                    lo_d = w_sq;
                    hi_d = w_sr;
                end
            end
            MD_DIVU: begin
                if (w_b_nz) begin
                    lo_d = w_qu;
                    hi_d = w_ru;
                end
            end
            default: ;
        endcase
    end

    // ------------------------------------------------------------------
    // Controller FSM with operand latches and HI/LO
    // ------------------------------------------------------------------
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_q <= S_IDLE;
            busy_q  <= 1'b0;
            op_q    <= MD_MULT;
            a_q     <= '0;
            b_q     <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (w_start_acc) begin
                        a_q     <= rs_val_i;
                        b_q     <= rt_val_i;
                        op_q    <= md_op_e'(md_op_i);
                        state_q <= S_BUSY;
                        busy_q  <= 1'b1;
                    end else if (start_i && (md_op_i == MD_MTHI)) begin
                        hi_q <= rs_val_i;
                    end else if (start_i && (md_op_i == MD_MTLO)) begin
                        lo_q <= rs_val_i;
                    end
                end
                S_BUSY: begin
                    // start_i is ignored here: latches and counter hold.
                    if (w_cnt_done) begin
                        hi_q    <= hi_d;
                        lo_q    <= lo_d;
                        state_q <= S_IDLE;
                        busy_q  <= 1'b0;
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    // Combinational so the stall asserts in the same cycle as start.
    assign md_stall_o = d_is_md_i && (busy_q || w_start_acc);
    assign busy_o     = busy_q;
    assign hi_o       = hi_q;
    assign lo_o       = lo_q;

endmodule : mdu_ctrl
`default_nettype wire
